cancid_stream_ctx: RTL and testbench



---
 rtl/cancid_pkg.sv | 28 ++
 rtl/cancid_stream_ctx_if.sv | 42 ++++
 rtl/cancid_ctx_ram.sv | 40 ++++
 rtl/cancid_stream_ctx.sv | 180 ++++++++++++++++++
 tb/tb_cancid_stream_ctx.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cancid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cancid_pkg
// Brief    : Shared types, default widths and saturating increment.
// Revision : 1.0
// ============================================================================
package cancid_pkg;

    localparam int DEF_STATE_W     = 11;
    localparam int DEF_NUM_STREAMS = 64;
    localparam int DEF_COUNT_W     = 16;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_RUN    = 2'd2,
        ST_COMMIT = 2'd3
    } ctx_state_e;

    // Counters of any width up to 32 bits share one increment helper.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (inc && (v < max_v)) ? (v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cancid_stream_ctx_if.sv
`default_nettype none
// ============================================================================
// Module   : cancid_stream_ctx_if
// Brief    : Classifier, matcher and statistics signals of the context engine.
// Revision : 1.0
// ============================================================================
interface cancid_stream_ctx_if
    import cancid_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int SID_W   = $clog2(DEF_NUM_STREAMS),
    parameter int COUNT_W = DEF_COUNT_W
);
    logic               load_state;
    logic [SID_W-1:0]   stream_id;
    logic               new_stream_id;
    logic               enable;
    logic               eop;
    logic [STATE_W-1:0] m_state_in;
    logic               m_state_in_vld;
    logic [STATE_W-1:0] m_state_out;
    logic               m_accept;
    logic               fired;
    logic [COUNT_W-1:0] count;
    logic [SID_W-1:0]   stat_sid;
    logic [COUNT_W-1:0] stat_count;
    logic               busy;

    modport master (
        output load_state, stream_id, new_stream_id, enable, eop,
        output m_state_out, m_accept, stat_sid,
        input  m_state_in, m_state_in_vld, fired, count, stat_count, busy
    );

    modport slave (
        input  load_state, stream_id, new_stream_id, enable, eop,
        input  m_state_out, m_accept, stat_sid,
        output m_state_in, m_state_in_vld, fired, count, stat_count, busy
    );

endinterface
`default_nettype wire

// File: rtl/cancid_ctx_ram.sv
`default_nettype none
// ============================================================================
// Module   : cancid_ctx_ram
// Brief    : Per-stream {state, count} storage, one write and two async reads.
// Revision : 1.0
// ============================================================================
module cancid_ctx_ram
    import cancid_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int COUNT_W     = DEF_COUNT_W,
    parameter int NUM_STREAMS = DEF_NUM_STREAMS,
    parameter int SID_W       = $clog2(NUM_STREAMS)
) (
    input  wire logic                       clk,
    input  wire logic                       wr_en,
    input  wire logic [SID_W-1:0]           wr_addr,
    input  wire logic [STATE_W+COUNT_W-1:0] wr_data,
    input  wire logic [SID_W-1:0]           rd_addr,
    output logic      [STATE_W-1:0]         rd_state,
    output logic      [COUNT_W-1:0]         rd_count,
    input  wire logic [SID_W-1:0]           stat_addr,
    output logic      [COUNT_W-1:0]         stat_count
);
    localparam int ENTRY_W = STATE_W + COUNT_W;

    logic [ENTRY_W-1:0] mem_q [NUM_STREAMS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_state   = mem_q[rd_addr][ENTRY_W-1:COUNT_W];
    assign rd_count   = mem_q[rd_addr][COUNT_W-1:0];
    assign stat_count = mem_q[stat_addr][COUNT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/cancid_stream_ctx.sv
`default_nettype none
// ============================================================================
// Module   : cancid_stream_ctx
// Brief    : Per-stream matcher context save/restore with match counters.
// Revision : 1.0
// ============================================================================
module cancid_stream_ctx
    import cancid_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int NUM_STREAMS = DEF_NUM_STREAMS,
    parameter int SID_W       = $clog2(NUM_STREAMS),
    parameter int COUNT_W     = DEF_COUNT_W
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    cancid_stream_ctx_if.slave bus
);
    ctx_state_e         state_q, state_d;
    logic [SID_W-1:0]   idx_q, idx_d;
    logic [SID_W-1:0]   sid_q, sid_d;
    logic               fired_q, fired_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [STATE_W-1:0] m_state_in_q, m_state_in_d;
    logic               m_state_in_vld_q, m_state_in_vld_d;
    logic [COUNT_W-1:0] stat_count_q, stat_count_d;
    logic [STATE_W-1:0] st_l_q, st_l_d;
    logic               en_l_q, en_l_d;
    logic               fired_l_q, fired_l_d;
    logic [COUNT_W-1:0] cnt_l_q, cnt_l_d;

    logic                       wr_en;
    logic [SID_W-1:0]           wr_addr;
    logic [STATE_W+COUNT_W-1:0] wr_data;
    logic [SID_W-1:0]           rd_addr;
    logic [STATE_W-1:0]         rd_state;
    logic [COUNT_W-1:0]         rd_count;
    logic [COUNT_W-1:0]         ram_stat_count;
    logic                       do_load;
    logic                       fwd;

    cancid_ctx_ram #(
        .STATE_W     (STATE_W),
        .COUNT_W     (COUNT_W),
        .NUM_STREAMS (NUM_STREAMS),
        .SID_W       (SID_W)
    ) u_ram (
        .clk        (clk),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_state   (rd_state),
        .rd_count   (rd_count),
        .stat_addr  (bus.stat_sid),
        .stat_count (ram_stat_count)
    );

    // A load in the COMMIT cycle of the same stream must see the value being written.
    assign fwd = (state_q == ST_COMMIT) && en_l_q && (sid_q == bus.stream_id);

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        sid_d            = sid_q;
        fired_d          = fired_q;
        count_d          = count_q;
        m_state_in_d     = m_state_in_q;
        m_state_in_vld_d = 1'b0;
        stat_count_d     = ram_stat_count;
        st_l_d           = st_l_q;
        en_l_d           = en_l_q;
        fired_l_d        = fired_l_q;
        cnt_l_d          = cnt_l_q;
        wr_en            = 1'b0;
        wr_addr          = sid_q;
        wr_data          = {st_l_q, COUNT_W'(sat_inc(32'(cnt_l_q), fired_l_q, COUNT_W))};
        rd_addr          = bus.stream_id;
        do_load          = 1'b0;

        case (state_q)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = '0;
                idx_d   = idx_q + SID_W'(1);
                if (idx_q == SID_W'(NUM_STREAMS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                do_load = bus.load_state;
            end
            ST_RUN: begin
                if (bus.load_state) begin
                    do_load = 1'b1;
                end else begin
                    if (bus.m_accept) begin
                        fired_d = 1'b1;
                    end
                    if (bus.eop) begin
                        // Old count is captured now so COMMIT needs no second read port.
                        rd_addr   = sid_q;
                        st_l_d    = bus.m_state_out;
                        en_l_d    = bus.enable;
                        fired_l_d = fired_q | bus.m_accept;
                        cnt_l_d   = rd_count;
                        state_d   = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                if (en_l_q) begin
                    wr_en   = 1'b1;
                    count_d = COUNT_W'(sat_inc(32'(count_q), fired_l_q, COUNT_W));
                end else begin
                    fired_d = 1'b0;
                end
                state_d = ST_IDLE;
                do_load = bus.load_state;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (do_load) begin
            sid_d            = bus.stream_id;
            fired_d          = 1'b0;
            m_state_in_vld_d = 1'b1;
            state_d          = ST_RUN;
            if (bus.new_stream_id) begin
                m_state_in_d = '0;
            end else if (fwd) begin
                m_state_in_d = st_l_q;
            end else begin
                m_state_in_d = rd_state;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_INIT;
            idx_q            <= '0;
            sid_q            <= '0;
            fired_q          <= 1'b0;
            count_q          <= '0;
            m_state_in_q     <= '0;
            m_state_in_vld_q <= 1'b0;
            stat_count_q     <= '0;
            st_l_q           <= '0;
            en_l_q           <= 1'b0;
            fired_l_q        <= 1'b0;
            cnt_l_q          <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            sid_q            <= sid_d;
            fired_q          <= fired_d;
            count_q          <= count_d;
            m_state_in_q     <= m_state_in_d;
            m_state_in_vld_q <= m_state_in_vld_d;
            stat_count_q     <= stat_count_d;
            st_l_q           <= st_l_d;
            en_l_q           <= en_l_d;
            fired_l_q        <= fired_l_d;
            cnt_l_q          <= cnt_l_d;
        end
    end

    assign bus.m_state_in     = m_state_in_q;
    assign bus.m_state_in_vld = m_state_in_vld_q;
    assign bus.fired          = fired_q;
    assign bus.count          = count_q;
    assign bus.stat_count     = stat_count_q;
    assign bus.busy           = (state_q == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_cancid_stream_ctx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cancid_stream_ctx
// Brief    : Directed self-checking bench for cancid_stream_ctx (COUNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_cancid_stream_ctx;
    localparam int STATE_W = 11;
    localparam int NS      = 64;
    localparam int SID_W   = 6;
    localparam int COUNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    cancid_stream_ctx_if #(.STATE_W(STATE_W), .SID_W(SID_W), .COUNT_W(COUNT_W)) bus ();

    cancid_stream_ctx #(
        .STATE_W     (STATE_W),
        .NUM_STREAMS (NS),
        .SID_W       (SID_W),
        .COUNT_W     (COUNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.load_state    = 1'b0;
        bus.stream_id     = '0;
        bus.new_stream_id = 1'b0;
        bus.enable        = 1'b0;
        bus.eop           = 1'b0;
        bus.m_state_out   = '0;
        bus.m_accept      = 1'b0;
        bus.stat_sid      = '0;
    endtask

    task automatic load(input logic [SID_W-1:0] sid, input logic nw);
        bus.load_state    = 1'b1;
        bus.stream_id     = sid;
        bus.new_stream_id = nw;
        cyc();
        bus.load_state    = 1'b0;
        bus.new_stream_id = 1'b0;
    endtask

    task automatic send_eop(input logic en, input logic [STATE_W-1:0] st, input logic acc);
        bus.eop         = 1'b1;
        bus.enable      = en;
        bus.m_state_out = st;
        bus.m_accept    = acc;
        cyc();
        bus.eop      = 1'b0;
        bus.enable   = 1'b0;
        bus.m_accept = 1'b0;
    endtask

    task automatic pulse_accept();
        bus.m_accept = 1'b1;
        cyc();
        bus.m_accept = 1'b0;
        cyc();
    endtask

    task automatic read_stat(input logic [SID_W-1:0] sid, output logic [COUNT_W-1:0] v);
        bus.stat_sid = sid;
        cyc();
        v = bus.stat_count;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            cyc();
        end
        tests++;
        if (n !== 64) begin
            fails++;
            $display("FAIL init_len: busy cycles %0d, expected 64", n);
        end
    endtask

    task automatic test_reset();
        logic [COUNT_W-1:0] v;
        drive_idle();
        rst_n = 1'b0;
        repeat (3) cyc();
        tests += 6;
        if (bus.busy !== 1'b1)           begin fails++; $display("FAIL rst_busy: got %b exp 1", bus.busy); end
        if (bus.count !== 4'd0)          begin fails++; $display("FAIL rst_count: got %0d exp 0", bus.count); end
        if (bus.fired !== 1'b0)          begin fails++; $display("FAIL rst_fired: got %b exp 0", bus.fired); end
        if (bus.m_state_in_vld !== 1'b0) begin fails++; $display("FAIL rst_vld: got %b exp 0", bus.m_state_in_vld); end
        if (bus.m_state_in !== 11'd0)    begin fails++; $display("FAIL rst_state_in: got %h exp 0", bus.m_state_in); end
        if (bus.stat_count !== 4'd0)     begin fails++; $display("FAIL rst_stat: got %0d exp 0", bus.stat_count); end
        rst_n = 1'b1;
        wait_init();
        tests++;
        if (bus.count !== 4'd0) begin fails++; $display("FAIL init_count: got %0d exp 0", bus.count); end
        for (int s = 0; s < NS; s++) begin
            read_stat(SID_W'(s), v);
            tests++;
            if (v !== 4'd0) begin fails++; $display("FAIL init_stat sid %0d: got %0d exp 0", s, v); end
        end
    endtask

    task automatic test_new_stream();
        logic [COUNT_W-1:0] v;
        load(6'd5, 1'b1);
        tests += 3;
        if (bus.m_state_in_vld !== 1'b1) begin fails++; $display("FAIL new_vld: got %b exp 1", bus.m_state_in_vld); end
        if (bus.m_state_in !== 11'd0)    begin fails++; $display("FAIL new_state_in: got %h exp 0", bus.m_state_in); end
        if (bus.fired !== 1'b0)          begin fails++; $display("FAIL new_fired: got %b exp 0", bus.fired); end
        cyc();
        tests++;
        if (bus.m_state_in_vld !== 1'b0) begin fails++; $display("FAIL vld_pulse: got %b exp 0", bus.m_state_in_vld); end
        pulse_accept();
        tests++;
        if (bus.fired !== 1'b1) begin fails++; $display("FAIL accept_fired: got %b exp 1", bus.fired); end
        pulse_accept();
        pulse_accept();
        send_eop(1'b1, 11'h2A5, 1'b0);
        cyc();
        tests++;
        if (bus.count !== 4'd1) begin fails++; $display("FAIL commit_count: got %0d exp 1", bus.count); end
        read_stat(6'd5, v);
        tests++;
        if (v !== 4'd1) begin fails++; $display("FAIL commit_stat5: got %0d exp 1", v); end
        load(6'd5, 1'b0);
        tests++;
        if (bus.m_state_in !== 11'h2A5) begin fails++; $display("FAIL restore5: got %h exp 2a5", bus.m_state_in); end
        send_eop(1'b0, 11'h000, 1'b0);
        cyc();
    endtask

    task automatic test_disabled();
        logic [COUNT_W-1:0] v;
        load(6'd5, 1'b0);
        pulse_accept();
        send_eop(1'b0, 11'h111, 1'b0);
        cyc();
        tests += 2;
        if (bus.fired !== 1'b0) begin fails++; $display("FAIL dis_fired: got %b exp 0", bus.fired); end
        if (bus.count !== 4'd1) begin fails++; $display("FAIL dis_count: got %0d exp 1", bus.count); end
        read_stat(6'd5, v);
        tests++;
        if (v !== 4'd1) begin fails++; $display("FAIL dis_stat5: got %0d exp 1", v); end
        load(6'd5, 1'b0);
        tests++;
        if (bus.m_state_in !== 11'h2A5) begin fails++; $display("FAIL dis_mem5: got %h exp 2a5", bus.m_state_in); end
        send_eop(1'b0, 11'h000, 1'b0);
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [COUNT_W-1:0] v;
        load(6'd7, 1'b1);
        send_eop(1'b1, 11'h0F0, 1'b0);
        cyc();
        load(6'd7, 1'b0);
        tests++;
        if (bus.m_state_in !== 11'h0F0) begin fails++; $display("FAIL b2b_old7: got %h exp 0f0", bus.m_state_in); end
        pulse_accept();
        send_eop(1'b1, 11'h3C3, 1'b0);
        load(6'd7, 1'b0);
        tests += 4;
        if (bus.m_state_in_vld !== 1'b1) begin fails++; $display("FAIL b2b_vld: got %b exp 1", bus.m_state_in_vld); end
        if (bus.m_state_in !== 11'h3C3)  begin fails++; $display("FAIL b2b_fwd: got %h exp 3c3", bus.m_state_in); end
        if (bus.fired !== 1'b0)          begin fails++; $display("FAIL b2b_fired: got %b exp 0", bus.fired); end
        if (bus.count !== 4'd2)          begin fails++; $display("FAIL b2b_count: got %0d exp 2", bus.count); end
        read_stat(6'd7, v);
        tests++;
        if (v !== 4'd1) begin fails++; $display("FAIL b2b_stat7: got %0d exp 1", v); end
        send_eop(1'b0, 11'h000, 1'b0);
        cyc();
    endtask

    task automatic test_abort();
        logic [COUNT_W-1:0] v;
        load(6'd3, 1'b1);
        send_eop(1'b1, 11'h155, 1'b0);
        cyc();
        load(6'd3, 1'b0);
        bus.m_state_out = 11'h7FF;
        pulse_accept();
        tests++;
        if (bus.fired !== 1'b1) begin fails++; $display("FAIL abort_pre_fired: got %b exp 1", bus.fired); end
        load(6'd3, 1'b0);
        tests += 3;
        if (bus.m_state_in_vld !== 1'b1) begin fails++; $display("FAIL abort_vld: got %b exp 1", bus.m_state_in_vld); end
        if (bus.m_state_in !== 11'h155)  begin fails++; $display("FAIL abort_state: got %h exp 155", bus.m_state_in); end
        if (bus.fired !== 1'b0)          begin fails++; $display("FAIL abort_fired: got %b exp 0", bus.fired); end
        repeat (2) cyc();
        tests++;
        if (bus.count !== 4'd2) begin fails++; $display("FAIL abort_count: got %0d exp 2", bus.count); end
        read_stat(6'd3, v);
        tests++;
        if (v !== 4'd0) begin fails++; $display("FAIL abort_stat3: got %0d exp 0", v); end
        send_eop(1'b0, 11'h000, 1'b0);
        cyc();
    endtask

    task automatic test_saturation();
        logic [COUNT_W-1:0] v;
        for (int i = 0; i < 20; i++) begin
            load(6'd2, (i == 0));
            send_eop(1'b1, 11'(i + 1), 1'b1);
            cyc();
            if (i == 4) begin
                tests++;
                if (bus.count !== 4'd7) begin fails++; $display("FAIL sat_mid_count: got %0d exp 7", bus.count); end
            end
        end
        tests++;
        if (bus.count !== 4'd15) begin fails++; $display("FAIL sat_count: got %0d exp 15", bus.count); end
        read_stat(6'd2, v);
        tests++;
        if (v !== 4'd15) begin fails++; $display("FAIL sat_stat2: got %0d exp 15", v); end
        load(6'd2, 1'b0);
        tests++;
        if (bus.m_state_in !== 11'd20) begin fails++; $display("FAIL sat_state2: got %h exp 014", bus.m_state_in); end
        send_eop(1'b1, 11'd21, 1'b1);
        cyc();
        tests++;
        if (bus.count !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d exp 15", bus.count); end
    endtask

    task automatic test_reset_mid_packet();
        load(6'd4, 1'b1);
        pulse_accept();
        #2;
        rst_n = 1'b0;
        #1;
        tests += 3;
        if (bus.fired !== 1'b0) begin fails++; $display("FAIL mid_rst_fired: got %b exp 0", bus.fired); end
        if (bus.count !== 4'd0) begin fails++; $display("FAIL mid_rst_count: got %0d exp 0", bus.count); end
        if (bus.busy !== 1'b1)  begin fails++; $display("FAIL mid_rst_busy: got %b exp 1", bus.busy); end
        cyc();
        rst_n = 1'b1;
        wait_init();
    endtask

    initial begin
        test_reset();
        test_new_stream();
        test_disabled();
        test_back_to_back();
        test_abort();
        test_saturation();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
